exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Execute/memory datapath directly downstream of the control unit.
- Consumes operand1, operand2, offset, opcode, sel1, sel3 and w_r, and returns result2 to the control unit for write-back.
- Contains a registered ALU, a 32-entry synchronous data memory and the result-select mux.
- Supports std_op (ALU result), loadR (memory read at base+offset) and storeR (memory write at base+offset).

Parameters:
- DATA_WIDTH, 8, width of operands, ALU result and memory words.
- ADDR_BITS, 5, data memory address width (2^ADDR_BITS words).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- operand1  in  DATA_WIDTH  ALU A input; base address for loadR/storeR.
- operand2  in  DATA_WIDTH  ALU B input when sel3=0; store data when w_r=1.
- offset  in  DATA_WIDTH  ALU B input when sel3=1.
- opcode  in  4  ALU operation.
- sel1  in  1  1: result2=alu_q; 0: result2=data_out_q.
- sel3  in  1  1: ALU B=offset; 0: ALU B=operand2.
- w_r  in  1  data memory write enable.
- result2  out  DATA_WIDTH  result back to the control unit.
- zero_flag  out  1  alu_q==0, registered.
- carry_flag  out  1  carry-out of ADD/INC, borrow of SUB/DEC, registered.

Behaviour:
- Reset (rst=0, asynchronous): alu_q=0, data_out_q=0, zero_flag=1, carry_flag=0. result2 therefore reads 0. Memory contents are not cleared by reset.
- ALU B mux: B = sel3 ? offset : operand2.
- ALU arithmetic is DATA_WIDTH+1 bits wide. Bit DATA_WIDTH is carry/borrow. Result is the low DATA_WIDTH bits, wrapping modulo 2^DATA_WIDTH.
- Opcodes:
  - 0000 ADD A+B
  - 0001 SUB A-B (borrow=1 iff A<B)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT A
  - 0110 SHL A by 1 (carry = A msb)
  - 0111 SHR A by 1 logical (carry = A lsb)
  - 1000 INC A
  - 1001 DEC A
  - 1010 pass A
  - 1011 pass B
  - 1100-1110 reserved, treated as pass A with carry=0
  - 1111 NOP: alu_q and both flags hold
- Carry is 0 for logic ops and pass ops.
- Per cycle, every rising edge:
  - alu_q <= alu_comb (except NOP).
  - carry_flag updates with alu_q.
  - zero_flag <= (alu_comb==0).
- Memory address = alu_comb[ADDR_BITS-1:0]. Upper bits are ignored, so addresses wrap.
- Memory write: on a rising edge with w_r=1, mem[addr] <= operand2.
- Memory read: every rising edge, data_out_q <= mem[addr] (synchronous, read-first). If the same address is written in the same cycle, data_out_q receives the OLD contents.
- result2 = sel1 ? alu_q : data_out_q (combinational mux of registered values). Latency from stable inputs to result2 is exactly one clock.
- Alignment with the control unit sequence:
  - std_op: operands set at DECODE edge; alu_q captured at EXECUTE edge; result2 valid during WRITE_BACK.
  - loadR: address valid in the EXECUTE cycle; data_out_q captured at EXECUTE edge; result2 valid during MEM_ACCESS and WRITE_BACK.
  - storeR: w_r=1 during the MEM_ACCESS cycle produces exactly one write.
- Reset mid-operation: registers clear immediately. An in-progress write whose edge has not occurred is dropped. Memory retains previously written data.
- No internal FSM: the block is fully sequenced by the control unit. w_r held high for N cycles writes N times (idempotent for the same inputs).

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_ADD..OP_NOP=4'b1111).
  - DATA_WIDTH/ADDR_BITS defaults.
  - Instruction-type codes: std_op=2'b01, loadR=2'b10, storeR=2'b11.
- Sub-module data_mem: synchronous single-port RAM, read-first, parameterised by DATA_WIDTH/ADDR_BITS.
- ALU and muxes stay in exec_mem_unit.

Test Plan:
- Reset: hold rst=0 with random inputs -> result2=0, zero_flag=1, carry_flag=0; release; opcode=1111 -> outputs hold.
- ADD overflow: operand1=8'hF0, operand2=8'h20, sel3=0, sel1=1, opcode=0000 -> one edge later result2=8'h10, carry_flag=1, zero_flag=0.
- SUB to zero: operand1=operand2=8'h05, opcode=0001 -> result2=0, zero_flag=1, carry_flag=0; then operand1=3, operand2=5 -> result2=8'hFE, carry_flag=1.
- Store then load: operand1=8'd2, offset=8'd5, sel3=1, opcode=0000, operand2=8'hA5, w_r=1 for one edge (mem[7]=A5); then w_r=0, sel1=0 -> next edge result2=8'hA5.
- Address wrap / read-first: operand1=8'd30, offset=8'd3 (addr 1), w_r=1, operand2=8'h3C with mem[1] previously 8'h11 -> data_out_q=8'h11 that edge, 8'h3C on following edge.
- Async reset mid-store: assert rst low between edges while w_r=1 -> no write occurs at the next edge (read mem[addr] afterwards returns old value), registers at reset values.

Source files
------------

// File: rtl/exec_mem_unit_pkg.sv
// Shared constants for the execute/memory stage: ALU opcodes, default widths
// and the instruction-type codes used by the control unit.
package exec_mem_unit_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_BITS_DEF  = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_PASA = 4'b1010;
  localparam logic [3:0] OP_PASB = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    INSTR_STD_OP = 2'b01,
    INSTR_LOADR  = 2'b10,
    INSTR_STORER = 2'b11
  } instr_type_e;

  // Codes 1100..1110 are reserved and behave as pass-A with no carry.
  function automatic logic is_reserved_op(input logic [3:0] op);
    return (op >= 4'b1100) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/exec_mem_unit_if.sv
// Control-unit <-> execute/memory stage bundle; master is the control unit.
interface exec_mem_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] offset;
  logic [3:0]            opcode;
  logic                  sel1;
  logic                  sel3;
  logic                  w_r;
  logic [DATA_WIDTH-1:0] result2;
  logic                  zero_flag;
  logic                  carry_flag;

  modport master (
    output operand1, operand2, offset, opcode, sel1, sel3, w_r,
    input  result2, zero_flag, carry_flag
  );

  modport slave (
    input  operand1, operand2, offset, opcode, sel1, sel3, w_r,
    output result2, zero_flag, carry_flag
  );
endinterface

// File: rtl/exec_mem_unit_data_mem.sv
// Single-port synchronous data RAM, read-first. Only the read register is
// reset; array contents survive reset and a write is dropped while reset is low.
module exec_mem_unit_data_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_addr];
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: registered ALU with flags, data memory addressed by
// the ALU result, and the write-back select mux. Sequenced by the control unit.
module exec_mem_unit
  import exec_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_mem_unit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] w_alu_a;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [DATA_WIDTH:0]   w_alu_full;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_nop;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [DATA_WIDTH-1:0] w_data_out;

  logic [DATA_WIDTH-1:0] r_alu_q;
  logic                  r_zero;
  logic                  r_carry;

  assign w_alu_a = bus.operand1;
  assign w_alu_b = bus.sel3 ? bus.offset : bus.operand2;

  // Bit DATA_WIDTH of w_alu_full carries the carry/borrow for every opcode.
  always_comb begin
    w_alu_full = '0;
    w_nop      = 1'b0;
    case (bus.opcode)
      OP_ADD:  w_alu_full = {1'b0, w_alu_a} + {1'b0, w_alu_b};
      OP_SUB:  w_alu_full = {1'b0, w_alu_a} - {1'b0, w_alu_b};
      OP_AND:  w_alu_full = {1'b0, w_alu_a & w_alu_b};
      OP_OR:   w_alu_full = {1'b0, w_alu_a | w_alu_b};
      OP_XOR:  w_alu_full = {1'b0, w_alu_a ^ w_alu_b};
      OP_NOT:  w_alu_full = {1'b0, ~w_alu_a};
      OP_SHL:  w_alu_full = {w_alu_a, 1'b0};
      OP_SHR:  w_alu_full = {w_alu_a[0], 1'b0, w_alu_a[DATA_WIDTH-1:1]};
      OP_INC:  w_alu_full = {1'b0, w_alu_a} + {{DATA_WIDTH{1'b0}}, 1'b1};
      OP_DEC:  w_alu_full = {1'b0, w_alu_a} - {{DATA_WIDTH{1'b0}}, 1'b1};
      OP_PASA: w_alu_full = {1'b0, w_alu_a};
      OP_PASB: w_alu_full = {1'b0, w_alu_b};
      OP_NOP: begin
        // Holding: the memory address also follows the held ALU value.
        w_nop      = 1'b1;
        w_alu_full = {1'b0, r_alu_q};
      end
      default: w_alu_full = {1'b0, w_alu_a};
    endcase
  end

  assign w_alu_res = w_alu_full[DATA_WIDTH-1:0];
  assign w_addr    = w_alu_res[ADDR_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_q <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else if (!w_nop) begin
      r_alu_q <= w_alu_res;
      r_zero  <= (w_alu_res == '0);
      r_carry <= w_alu_full[DATA_WIDTH];
    end
  end

  exec_mem_unit_data_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_data_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (bus.w_r),
    .i_addr  (w_addr),
    .i_wdata (bus.operand2),
    .o_rdata (w_data_out)
  );

  assign bus.result2    = bus.sel1 ? r_alu_q : w_data_out;
  assign bus.zero_flag  = r_zero;
  assign bus.carry_flag = r_carry;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed scenarios plus random traffic checked
// against an arithmetic reference model of the ALU, flags and data memory.
module tb_exec_mem_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  exec_mem_unit_if #(.DATA_WIDTH(8)) bus();

  exec_mem_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m_alu;
  bit m_zf;
  bit m_cf;
  int m_dout;
  bit m_dval;
  int m_mem [32];
  bit m_val [32];

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int res, output bit c);
    int s;
    c = 1'b0;
    case (op)
      0:  begin s = a + b; res = s % 256; c = (s > 255); end
      1:  begin res = (a - b + 256) % 256; c = (a < b); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = 255 - a;
      6:  begin res = (a * 2) % 256; c = (a >= 128); end
      7:  begin res = a / 2; c = (a % 2 == 1); end
      8:  begin res = (a + 1) % 256; c = (a == 255); end
      9:  begin res = (a + 255) % 256; c = (a == 0); end
      11: res = b;
      default: res = a;
    endcase
  endfunction

  function automatic int exp_r2(input bit s1);
    return s1 ? m_alu : m_dout;
  endfunction

  task automatic model_reset();
    m_alu  = 0;
    m_zf   = 1'b1;
    m_cf   = 1'b0;
    m_dout = 0;
    m_dval = 1'b1;
  endtask

  task automatic set_inputs(input int op, input int a, input int b, input int off,
                            input bit s1, input bit s3, input bit wr);
    bus.opcode   = 4'(op);
    bus.operand1 = 8'(a);
    bus.operand2 = 8'(b);
    bus.offset   = 8'(off);
    bus.sel1     = s1;
    bus.sel3     = s3;
    bus.w_r      = wr;
  endtask

  // Applies one set of inputs across one rising edge and advances the model.
  task automatic drive_cycle(input int op, input int a, input int b, input int off,
                             input bit s1, input bit s3, input bit wr);
    int res;
    bit c;
    int addr;
    int bval;
    set_inputs(op, a, b, off, s1, s3, wr);
    bval = s3 ? off : b;
    res = m_alu;
    c = m_cf;
    if (op != 15) ref_alu(op, a, bval, res, c);
    addr = res % 32;
    m_dout = m_mem[addr];
    m_dval = m_val[addr];
    if (wr) begin
      m_mem[addr] = b;
      m_val[addr] = 1'b1;
    end
    if (op != 15) begin
      m_alu = res;
      m_zf  = (res == 0);
      m_cf  = c;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_inputs($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), i[0], 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      vectors++;
      if (bus.result2 !== 8'h00 || bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got r2=%h z=%b c=%b want r2=00 z=1 c=0",
                 bus.result2, bus.zero_flag, bus.carry_flag);
      end
    end
    model_reset();
    set_inputs(15, 8'h5A, 8'h33, 8'h77, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(15, $urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus.result2 !== 8'h00 || bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin
        miscompares++;
        $display("FAIL nop_after_reset: got r2=%h z=%b c=%b want r2=00 z=1 c=0",
                 bus.result2, bus.zero_flag, bus.carry_flag);
      end
    end
  endtask

  task automatic test_mem_init();
    for (int i = 0; i < 32; i++) begin
      drive_cycle(0, i, $urandom_range(0, 255), 0, 1'b1, 1'b1, 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      drive_cycle(10, i, 0, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.result2 !== 8'(m_mem[i])) begin
        miscompares++;
        $display("FAIL mem_init[%0d]: got %h want %h", i, bus.result2, m_mem[i]);
      end
    end
  endtask

  task automatic test_add_overflow();
    drive_cycle(0, 8'hF0, 8'h20, 0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.result2 !== 8'h10 || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL add_overflow: got r2=%h c=%b z=%b want r2=10 c=1 z=0",
               bus.result2, bus.carry_flag, bus.zero_flag);
    end
  endtask

  task automatic test_sub();
    drive_cycle(1, 8'h05, 8'h05, 0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.result2 !== 8'h00 || bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_zero: got r2=%h z=%b c=%b want r2=00 z=1 c=0",
               bus.result2, bus.zero_flag, bus.carry_flag);
    end
    drive_cycle(1, 8'h03, 8'h05, 0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.result2 !== 8'hFE || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow: got r2=%h c=%b z=%b want r2=fe c=1 z=0",
               bus.result2, bus.carry_flag, bus.zero_flag);
    end
  endtask

  task automatic test_store_load();
    drive_cycle(0, 8'd2, 8'hA5, 8'd5, 1'b1, 1'b1, 1'b1);
    drive_cycle(0, 8'd2, 8'h00, 8'd5, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.result2 !== 8'hA5) begin
      miscompares++;
      $display("FAIL store_load: got %h want a5", bus.result2);
    end
  endtask

  task automatic test_wrap_read_first();
    drive_cycle(0, 8'd0, 8'h11, 8'd1, 1'b1, 1'b1, 1'b1);
    drive_cycle(0, 8'd30, 8'h3C, 8'd3, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (bus.result2 !== 8'h11) begin
      miscompares++;
      $display("FAIL read_first_old: got %h want 11", bus.result2);
    end
    drive_cycle(0, 8'd30, 8'h00, 8'd3, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.result2 !== 8'h3C) begin
      miscompares++;
      $display("FAIL wrap_new: got %h want 3c", bus.result2);
    end
  endtask

  task automatic test_random();
    int op;
    bit s1;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 15);
      s1 = 1'($urandom);
      drive_cycle(op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  s1, 1'($urandom), ($urandom_range(0, 3) == 0));
      if (s1 || m_dval) begin
        vectors++;
        if (bus.result2 !== 8'(exp_r2(s1))) begin
          miscompares++;
          $display("FAIL rand_r2 #%0d op=%0d sel1=%0b: got %h want %h",
                   i, op, s1, bus.result2, exp_r2(s1));
        end
      end
      vectors++;
      if (bus.zero_flag !== m_zf || bus.carry_flag !== m_cf) begin
        miscompares++;
        $display("FAIL rand_flags #%0d op=%0d: got z=%b c=%b want z=%b c=%b",
                 i, op, bus.zero_flag, bus.carry_flag, m_zf, m_cf);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Repeated writes with identical inputs must leave the same contents.
    for (int i = 0; i < 3; i++) drive_cycle(0, 8'd12, 8'h6B, 8'd0, 1'b1, 1'b1, 1'b1);
    drive_cycle(10, 8'd12, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.result2 !== 8'h6B) begin
      miscompares++;
      $display("FAIL back_to_back: got %h want 6b", bus.result2);
    end
  endtask

  task automatic test_reset_mid_store();
    drive_cycle(0, 8'd9, 8'h55, 8'd0, 1'b1, 1'b1, 1'b1);
    set_inputs(0, 8'd9, 8'hAA, 8'd0, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.result2 !== 8'h00 || bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got r2=%h z=%b c=%b want r2=00 z=1 c=0",
               bus.result2, bus.zero_flag, bus.carry_flag);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(0, 8'd9, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.result2 !== 8'h55) begin
      miscompares++;
      $display("FAIL reset_drops_write: got %h want 55", bus.result2);
    end
    bus.sel1 = 1'b1;
    #1;
    vectors++;
    if (bus.result2 !== 8'd9 || bus.zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_alu: got r2=%h z=%b want r2=09 z=0",
               bus.result2, bus.zero_flag);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_val[i] = 1'b0;
    end
    model_reset();
    set_inputs(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    test_reset();
    test_mem_init();
    test_add_overflow();
    test_sub();
    test_store_load();
    test_wrap_read_first();
    test_random();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
